// File: rtl/led_seq_pkg.sv
// Shared mode encoding and per-mode start patterns for the LED sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_COUNT = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam logic [2:0] PAT_OFF   = 3'b000;
  localparam logic [2:0] PAT_COUNT = 3'b000;
  localparam logic [2:0] PAT_CHASE = 3'b001;
  localparam logic [2:0] PAT_BLINK = 3'b111;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   next_mode = MODE_COUNT;
      MODE_COUNT: next_mode = MODE_CHASE;
      MODE_CHASE: next_mode = MODE_BLINK;
      MODE_BLINK: next_mode = MODE_OFF;
      default:    next_mode = MODE_OFF;
    endcase
  endfunction

  function automatic logic [2:0] init_pattern(input mode_e m);
    case (m)
      MODE_OFF:   init_pattern = PAT_OFF;
      MODE_COUNT: init_pattern = PAT_COUNT;
      MODE_CHASE: init_pattern = PAT_CHASE;
      MODE_BLINK: init_pattern = PAT_BLINK;
      default:    init_pattern = PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 and pulses tick while at the last count.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // clr restarts the period so the first step lands TICK_DIV edges after it
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// Button-driven LED pattern sequencer: short press cycles modes, long press forces OFF.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV    = 4,
  parameter int LONG_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       led,
  output logic       led2,
  output logic       led3,
  output logic [1:0] mode
);

  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              btn_q;
  logic              armed_q;
  logic              long_fired_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  mode_e             mode_q;
  mode_e             mode_d;
  logic [2:0]        pat_q;
  logic              short_ev;
  logic              long_ev;
  logic              mode_chg;
  logic              tick;

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    sat_inc = (v == HOLD_MAX) ? v : v + HOLD_W'(1);
  endfunction

  function automatic logic [2:0] step_pattern(input mode_e m, input logic [2:0] p);
    case (m)
      MODE_COUNT: step_pattern = p + 3'd1;
      MODE_CHASE: step_pattern = {p[1:0], p[2]};
      MODE_BLINK: step_pattern = ~p;
      default:    step_pattern = PAT_OFF;
    endcase
  endfunction

  // Events are gated by armed_q so a button held through reset never counts.
  always_comb begin
    hold_d   = btn ? sat_inc(hold_q) : '0;
    long_ev  = armed_q && btn && (hold_q == HOLD_LAST);
    short_ev = armed_q && !btn && btn_q && !long_fired_q;
    mode_chg = long_ev || short_ev;
    mode_d   = next_mode(mode_q);
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .clr (mode_chg),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q        <= 1'b0;
      armed_q      <= 1'b0;
      long_fired_q <= 1'b0;
      hold_q       <= '0;
      mode_q       <= MODE_OFF;
      pat_q        <= PAT_OFF;
    end else begin
      btn_q        <= btn;
      hold_q       <= hold_d;
      armed_q      <= armed_q | ~btn;
      long_fired_q <= btn ? (long_fired_q | long_ev) : 1'b0;
      // A mode change wins over a coincident step tick.
      if (long_ev) begin
        mode_q <= MODE_OFF;
        pat_q  <= PAT_OFF;
      end else if (short_ev) begin
        mode_q <= mode_d;
        pat_q  <= init_pattern(mode_d);
      end else if (tick) begin
        pat_q  <= step_pattern(mode_q, pat_q);
      end
    end
  end

  assign led  = pat_q[0];
  assign led2 = pat_q[1];
  assign led3 = pat_q[2];
  assign mode = mode_q;

endmodule
